// File: rtl/bridge_pkg.sv
// Shared definitions for the APB timer slave: protocol states, register
// offsets and CTRL field positions.
package bridge_pkg;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

  // Byte offsets inside the slave window
  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_LOAD   = 8'h04;
  localparam logic [7:0] OFF_COUNT  = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_SCR0   = 8'h10;  // SCRATCH0..3 at 0x10..0x1C

  // CTRL field positions
  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_IRQ_EN   = 1;
  localparam int unsigned CTRL_AUTO     = 2;
  localparam int unsigned CTRL_PRESC_LO = 8;
  localparam int unsigned PRESC_W       = 8;

endpackage

// File: rtl/apb_timer_core.sv
// Prescaled 32-bit down-counter: owns the prescale counter, COUNT and the
// expired flag, and asks the parent to drop CTRL.en on a one-shot expiry.
module apb_timer_core
  import bridge_pkg::*;
#(
  parameter logic [31:0] LOAD_RESET = 32'h0000_0000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               auto_reload_i,
  input  logic [PRESC_W-1:0] presc_i,
  input  logic [31:0]        load_i,
  input  logic               load_we_i,
  input  logic [31:0]        load_wdata_i,
  input  logic               w1c_i,
  output logic [31:0]        count_o,
  output logic               expired_o,
  output logic               en_clr_o
);

  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [31:0]        count_q, count_d;
  logic               expired_q, expired_d;
  logic               tick, expire;

  assign tick   = en_i && (pcnt_q == presc_i);
  assign expire = tick && (count_q == 32'd0);

  // Next-state: a LOAD write overrides any decrement/reload on the same edge,
  // and a fresh expiry overrides a software W1C of the flag.
  always_comb begin
    pcnt_d    = pcnt_q;
    count_d   = count_q;
    expired_d = expired_q;
    if (!en_i || tick) pcnt_d = '0;
    else               pcnt_d = pcnt_q + 1'b1;
    if (load_we_i)                    count_d = load_wdata_i;
    else if (tick && !expire)         count_d = count_q - 32'd1;
    else if (expire && auto_reload_i) count_d = load_i;
    if (expire)     expired_d = 1'b1;
    else if (w1c_i) expired_d = 1'b0;
  end

  // Timer state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pcnt_q    <= '0;
      count_q   <= LOAD_RESET;
      expired_q <= 1'b0;
    end else begin
      pcnt_q    <= pcnt_d;
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign count_o   = count_q;
  assign expired_o = expired_q;
  assign en_clr_o  = expire && !auto_reload_i;

endmodule

// File: rtl/apb_timer_slave.sv
// APB2 responder: setup/access tracking, register decode, CTRL/LOAD/SCRATCH
// bank and registered read data; the timer itself lives in apb_timer_core.
module apb_timer_slave
  import bridge_pkg::*;
#(
  parameter int unsigned SEL_IDX    = 0,
  parameter int unsigned ADDR_W     = 12,
  parameter logic [31:0] LOAD_RESET = 32'h0000_0000
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        irq
);

  apb_state_e state_q, state_d;

  logic               sel, wr_en, rd_en;
  logic [ADDR_W-1:0]  off;
  logic               hit_ctrl, hit_load, hit_count, hit_status, hit_scr;
  logic [1:0]         scr_idx;

  logic               en_q, irq_en_q, auto_q;
  logic [PRESC_W-1:0] presc_q;
  logic [31:0]        load_q;
  logic [3:0][31:0]   scratch_q;
  logic [31:0]        prdata_q, rdata_mux;

  logic [31:0]        count;
  logic               expired, en_clr;

  // Upper address bits are decoded by the bridge; byte lanes are ignored.
  logic unused_addr;
  assign unused_addr = &{1'b0, Paddr[31:ADDR_W], Paddr[1:0]};

  assign sel = Pselx[SEL_IDX];
  assign off = {Paddr[ADDR_W-1:2], 2'b00};

  assign hit_ctrl   = (off == ADDR_W'(OFF_CTRL));
  assign hit_load   = (off == ADDR_W'(OFF_LOAD));
  assign hit_count  = (off == ADDR_W'(OFF_COUNT));
  assign hit_status = (off == ADDR_W'(OFF_STATUS));
  assign hit_scr    = ((off >> 4) == (ADDR_W'(OFF_SCR0) >> 4));
  assign scr_idx    = off[3:2];

  // Commit only from SETUP so a stray enable or a second access cycle never writes.
  assign wr_en = (state_q == APB_SETUP) && sel && Penable && Pwrite;
  assign rd_en = sel && !Penable && !Pwrite;

  // Protocol next-state
  always_comb begin
    state_d = APB_IDLE;
    case (state_q)
      APB_IDLE:   state_d = (sel && !Penable) ? APB_SETUP : APB_IDLE;
      APB_SETUP:  state_d = !sel ? APB_IDLE : (Penable ? APB_ACCESS : APB_SETUP);
      APB_ACCESS: state_d = (sel && !Penable) ? APB_SETUP : APB_IDLE;
      default:    state_d = APB_IDLE;
    endcase
  end

  // Protocol state register
  always_ff @(posedge Hclk) begin
    if (Hreset) state_q <= APB_IDLE;
    else        state_q <= state_d;
  end

  // CTRL: a software write wins over the core's one-shot en clear
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      auto_q   <= 1'b0;
      presc_q  <= '0;
    end else if (wr_en && hit_ctrl) begin
      en_q     <= Pwdata[CTRL_EN];
      irq_en_q <= Pwdata[CTRL_IRQ_EN];
      auto_q   <= Pwdata[CTRL_AUTO];
      presc_q  <= Pwdata[CTRL_PRESC_LO +: PRESC_W];
    end else if (en_clr) begin
      en_q     <= 1'b0;
    end
  end

  // LOAD and scratch registers
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      load_q    <= LOAD_RESET;
      scratch_q <= '0;
    end else begin
      if (wr_en && hit_load) load_q <= Pwdata;
      if (wr_en && hit_scr)  scratch_q[scr_idx] <= Pwdata;
    end
  end

  apb_timer_core #(.LOAD_RESET(LOAD_RESET)) u_core (
    .clk_i        (Hclk),
    .rst_i        (Hreset),
    .en_i         (en_q),
    .auto_reload_i(auto_q),
    .presc_i      (presc_q),
    .load_i       (load_q),
    .load_we_i    (wr_en && hit_load),
    .load_wdata_i (Pwdata),
    .w1c_i        (wr_en && hit_status && Pwdata[0]),
    .count_o      (count),
    .expired_o    (expired),
    .en_clr_o     (en_clr)
  );

  // Read mux; unmapped offsets return zero
  always_comb begin
    rdata_mux = 32'd0;
    if (hit_ctrl)
      rdata_mux = {16'd0, presc_q, 5'd0, auto_q, irq_en_q, en_q};
    else if (hit_load)   rdata_mux = load_q;
    else if (hit_count)  rdata_mux = count;
    else if (hit_status) rdata_mux = {31'd0, expired};
    else if (hit_scr)    rdata_mux = scratch_q[scr_idx];
  end

  // Read data captured in setup, held through the enable cycle
  always_ff @(posedge Hclk) begin
    if (Hreset)     prdata_q <= 32'd0;
    else if (rd_en) prdata_q <= rdata_mux;
  end

  assign Prdata = prdata_q;
  assign irq    = expired && irq_en_q;

endmodule

// File: tb/tb_apb_timer_slave.sv
// Directed bench for apb_timer_slave: register table plus timer, W1C race,
// stray-enable and reset-mid-transfer sequences.
module tb_apb_timer_slave;

  localparam int unsigned SEL   = 1;
  localparam logic [31:0] LR    = 32'h0000_0005;
  localparam logic [2:0]  MY    = 3'b010;
  localparam logic [2:0]  OTHER = 3'b001;

  logic        Hclk = 1'b0;
  logic        Hreset, Penable, Pwrite, irq;
  logic [2:0]  Pselx;
  logic [31:0] Paddr, Pwdata, Prdata;

  int n_tests = 0;
  int n_fail  = 0;

  apb_timer_slave #(.SEL_IDX(SEL), .ADDR_W(12), .LOAD_RESET(LR)) dut (
    .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable),
    .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata), .irq(irq)
  );

  always #5 Hclk = ~Hclk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic setup(input logic [2:0] s, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge Hclk);
    Pselx = s; Penable = 1'b0; Pwrite = w; Paddr = a; Pwdata = d;
  endtask

  task automatic enable();
    @(negedge Hclk);
    Penable = 1'b1;
  endtask

  task automatic idle();
    @(negedge Hclk);
    Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0;
  endtask

  // Leaves the bus in the access cycle so the next call can go back-to-back
  task automatic apb_wr(input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
    setup(s, 1'b1, a, d);
    enable();
  endtask

  task automatic apb_rd(input logic [31:0] a, output logic [31:0] d);
    setup(MY, 1'b0, a, 32'd0);
    enable();
    d = Prdata;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[$];
    logic [31:0] rd;
    logic [31:0] exp2 [12];

    Hreset = 1'b1; Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0;
    Paddr = 32'd0; Pwdata = 32'd0;
    repeat (3) @(negedge Hclk);
    Hreset = 1'b0;
    chk("reset_prdata", Prdata, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);

    // wr, addr, wdata, expected readback (reads only)
    vecs.push_back('{1'b0, 32'h00, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 32'h04, 32'h0, LR});
    vecs.push_back('{1'b0, 32'h08, 32'h0, LR});
    vecs.push_back('{1'b0, 32'h0C, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 32'h10, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 32'h14, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 32'h18, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 32'h1C, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 32'h20, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 32'h10, 32'hA5A5_5A5A, 32'h0});
    vecs.push_back('{1'b0, 32'h10, 32'h0, 32'hA5A5_5A5A});
    vecs.push_back('{1'b1, 32'h1C, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{1'b0, 32'h1C, 32'h0, 32'hFFFF_FFFF});
    vecs.push_back('{1'b1, 32'h00, 32'hFFFF_FFF8, 32'h0});
    vecs.push_back('{1'b0, 32'h00, 32'h0, 32'h0000_FF00});
    vecs.push_back('{1'b1, 32'h00, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 32'h00, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 32'h08, 32'h1234, 32'h0});
    vecs.push_back('{1'b0, 32'h08, 32'h0, LR});
    vecs.push_back('{1'b1, 32'h04, 32'h9, 32'h0});
    vecs.push_back('{1'b0, 32'h04, 32'h0, 32'h9});
    vecs.push_back('{1'b0, 32'h08, 32'h0, 32'h9});
    vecs.push_back('{1'b1, 32'h20, 32'h1111, 32'h0});
    vecs.push_back('{1'b0, 32'h20, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 32'h1000_0010, 32'h0, 32'hA5A5_5A5A});
    vecs.push_back('{1'b0, 32'h0000_0810, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 32'h0C, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{1'b0, 32'h0C, 32'h0, 32'h0});

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        apb_wr(MY, vecs[i].addr, vecs[i].wdata);
        idle();
      end else begin
        apb_rd(vecs[i].addr, rd);
        chk($sformatf("tbl%0d_rd_%h", i, vecs[i].addr), rd, vecs[i].exp);
      end
    end

    // Only the configured select bit may write
    apb_wr(MY, 32'h18, 32'hDEAD_BEEF);
    apb_wr(OTHER, 32'h18, 32'h1);
    idle();
    apb_rd(32'h18, rd);
    chk("scratch2_other_sel", rd, 32'hDEAD_BEEF);

    // One-shot, presc=0: repeated setup reads capture COUNT every cycle
    apb_wr(MY, 32'h04, 32'd3);
    apb_wr(MY, 32'h00, 32'h0000_0003);
    setup(MY, 1'b0, 32'h08, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge Hclk);
      chk($sformatf("oneshot_count%0d", k), Prdata, 32'(3 - k));
    end
    chk("oneshot_irq", {31'd0, irq}, 32'd1);
    enable();
    idle();
    apb_rd(32'h0C, rd); chk("oneshot_expired", rd, 32'd1);
    apb_rd(32'h00, rd); chk("oneshot_en_clr", rd, 32'h0000_0002);
    apb_rd(32'h08, rd); chk("oneshot_hold0", rd, 32'd0);
    apb_wr(MY, 32'h0C, 32'd1);
    idle();
    apb_rd(32'h0C, rd); chk("w1c_clear", rd, 32'd0);

    // Auto-reload, presc=2: one decrement every 3 cycles, reload to 2
    exp2 = '{32'd2, 32'd2, 32'd2, 32'd1, 32'd1, 32'd1,
             32'd0, 32'd0, 32'd0, 32'd2, 32'd2, 32'd2};
    apb_wr(MY, 32'h04, 32'd2);
    apb_wr(MY, 32'h00, 32'h0000_0207);
    setup(MY, 1'b0, 32'h08, 32'd0);
    for (int k = 0; k < 12; k++) begin
      @(negedge Hclk);
      chk($sformatf("reload_count%0d", k), Prdata, exp2[k]);
    end
    enable();
    idle();
    apb_rd(32'h0C, rd); chk("reload_expired", rd, 32'd1);
    chk("reload_irq", {31'd0, irq}, 32'd1);
    apb_rd(32'h00, rd); chk("reload_en_kept", rd, 32'h0000_0207);
    apb_wr(MY, 32'h00, 32'd0);
    apb_wr(MY, 32'h0C, 32'd1);
    idle();
    apb_rd(32'h0C, rd); chk("stop_clear", rd, 32'd0);

    // Expiry and W1C on the same edge: expiry wins
    apb_wr(MY, 32'h04, 32'd0);
    apb_wr(MY, 32'h00, 32'h0000_0103);
    apb_wr(MY, 32'h0C, 32'd1);
    idle();
    apb_rd(32'h0C, rd); chk("race_w1c_expired", rd, 32'd1);
    chk("race_w1c_irq", {31'd0, irq}, 32'd1);
    apb_rd(32'h00, rd); chk("race_w1c_en_clr", rd, 32'h0000_0102);
    apb_wr(MY, 32'h0C, 32'd1);
    idle();
    apb_rd(32'h0C, rd); chk("w1c_after_race", rd, 32'd0);
    chk("irq_dropped", {31'd0, irq}, 32'd0);

    // Expiry and CTRL write on the same edge: the write's en wins
    apb_wr(MY, 32'h00, 32'h0000_0101);
    apb_wr(MY, 32'h00, 32'h0000_0105);
    idle();
    apb_rd(32'h00, rd); chk("race_ctrl_wins", rd, 32'h0000_0105);
    apb_wr(MY, 32'h00, 32'd0);
    apb_wr(MY, 32'h0C, 32'd1);
    idle();

    // Enable without setup is ignored
    @(negedge Hclk);
    Pselx = MY; Penable = 1'b1; Pwrite = 1'b1; Paddr = 32'h10; Pwdata = 32'h0000_0BAD;
    repeat (3) @(negedge Hclk);
    idle();
    apb_rd(32'h10, rd); chk("stray_enable", rd, 32'hA5A5_5A5A);

    // Reset during setup, then an orphan enable cycle
    setup(MY, 1'b1, 32'h14, 32'h77);
    @(negedge Hclk);
    Hreset = 1'b1; Penable = 1'b1;
    @(negedge Hclk);
    Hreset = 1'b0;
    idle();
    apb_rd(32'h14, rd); chk("rst_mid_no_commit", rd, 32'd0);
    apb_rd(32'h10, rd); chk("rst_mid_scratch0", rd, 32'd0);
    apb_rd(32'h04, rd); chk("rst_mid_load", rd, LR);
    apb_wr(MY, 32'h14, 32'h55);
    idle();
    apb_rd(32'h14, rd); chk("post_rst_write", rd, 32'h55);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
